bulls_cows_core_param: RTL
==========================

Name: bulls_cows_core_param

Overview:
Parametrised successor game FSM for the Bulls-and-Cows (xAyB) number game. It generalises digit count, radix, chance count and duplicate policy. A cursor-indexed datapath replaces per-digit states. The block adds registered A/B scoring and restart-without-reset. It sits between the debounced button/switch/LFSR front end and the display/scoring modules.

Parameters:
NUM_DIGITS, 4, digits per code (2..8)
DIGIT_W, 4, bits per digit
RADIX, 10, legal digit values are 0..RADIX-1 (RADIX <= 2**DIGIT_W; RADIX >= NUM_DIGITS when ALLOW_DUP=0)
MAX_CHANCES, 5, wrong guesses allowed per game (>= 1)
ALLOW_DUP, 0, 1 = repeated digits permitted in both target and guess

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
p0_pulse  in  1  confirm, one-cycle pulse
p1_pulse  in  1  undo/back, one-cycle pulse
sw_val  in  DIGIT_W  switch digit
sw_valid  in  1  switch value is present
lfsr_val  in  DIGIT_W  random digit
state  out  3  encoding: IDLE=0, SET=1, GUESS=2, SHOW=3, WIN=4, LOSE=5
cursor  out  CW=max(1,$clog2(NUM_DIGITS))  digit index being entered; NUM_DIGITS-1 is entered first
target_flat  out  NUM_DIGITS*DIGIT_W  target code, digit i at [i*DIGIT_W +: DIGIT_W]
guess_flat  out  NUM_DIGITS*DIGIT_W  guess code, same packing
candidate  out  DIGIT_W  value that p0 would commit
cand_ok  out  1  candidate is legal at the current cursor
chances  out  $clog2(MAX_CHANCES+1)  remaining chances
result_a  out  $clog2(NUM_DIGITS+1)  bulls of last scored guess
result_b  out  $clog2(NUM_DIGITS+1)  cows of last scored guess
result_valid  out  1  high in SHOW, WIN and LOSE

Behaviour:
- Synchronous reset, which overrides everything, including mid-game:
  - state=IDLE, cursor=NUM_DIGITS-1, chances=MAX_CHANCES.
  - target_flat, guess_flat, result_a and result_b are 0.
- candidate is combinational:
  - In SET: sw_val if sw_valid, else lfsr_val.
  - In all other states: sw_val.
- cand_ok is combinational and requires all of the following:
  - candidate < RADIX.
  - In GUESS, sw_valid=1.
  - If ALLOW_DUP=0, candidate does not equal any already-committed digit at an index > cursor in the code currently being entered.
  - In states other than SET and GUESS, cand_ok=0.
- Each commit takes one cycle. A register updates on the clk edge that samples p0_pulse.
- Event priority in SET and GUESS:
  - p0_pulse && cand_ok commits the candidate; p1 in the same cycle is ignored.
  - Otherwise, p1_pulse performs undo.
  - An undo at cursor=NUM_DIGITS-1 has no effect.
- IDLE:
  - p0 -> SET, cursor=NUM_DIGITS-1, chances=MAX_CHANCES.
  - Clears target_flat, guess_flat, result_a and result_b.
- SET commit:
  - target[cursor] <= candidate.
  - If cursor>0: cursor decrements.
  - If cursor==0: go to GUESS with cursor=NUM_DIGITS-1.
- SET undo: cursor increments. The stale digit stays and is overwritten on the next commit.
- GUESS commit at cursor>0: guess[cursor] <= candidate, cursor decrements.
- GUESS commit at cursor==0 (scoring edge):
  - guess[0] <= candidate.
  - A and B are computed on the completed guess, with candidate substituted for digit 0.
  - A = count of positions i with guess[i]==target[i].
  - B = (sum over values v<RADIX of min(count of v in guess, count of v in target)) − A. When there are no duplicates this equals the positional cross-match count.
  - result_a and result_b are registered on the same edge.
  - If A==NUM_DIGITS: -> WIN; chances unchanged.
  - Else if chances==1: chances=0 -> LOSE.
  - Else: chances decrements -> SHOW.
- GUESS undo: cursor increments.
- SHOW:
  - p0 -> GUESS, cursor=NUM_DIGITS-1.
  - guess_flat is retained until overwritten; results hold until the next scoring edge.
- WIN and LOSE:
  - Hold all outputs.
  - p0 -> IDLE, with no register clears until the IDLE->SET transition.
- p1 in IDLE, SHOW, WIN or LOSE: ignored.
- lfsr_val ≥ RADIX with sw_valid=0 in SET: cand_ok=0 and the commit is rejected. The user retries on the next pulse.

Test Plan:
1. Defaults. Reset, p0, then set 1,2,3,4 via sw → state SET→GUESS after the 5th p0, target_flat=16'h1234, cursor=3, chances=5.
2. SET duplicate and undo. target[3]=1, sw=1, p0 → cand_ok=0, cursor stays 2. Then p1 → cursor=3. Then sw=7, p0 → target[3]=7.
3. Target 1234, guess 1,2,4,3 → on the 4th p0: state=SHOW, result_a=2, result_b=2, result_valid=1, chances=4. Then p0 → GUESS, cursor=3.
4. Guess 1234 → WIN, result_a=4, result_b=0, chances unchanged. Then p0 → IDLE. Then p0 → SET with target_flat=0 and chances=5.
5. Five guesses of 5678 → result_a=0, result_b=0, chances 4,3,2,1, then 0 with state=LOSE on the 5th scoring edge.
6. Edge cases:
   - sw=4'hA in GUESS → rejected.
   - sw_valid=0 in GUESS → rejected.
   - p0 and p1 in the same cycle with a legal candidate → commit only.
   - reset asserted at GUESS cursor=1 → all outputs at reset values next cycle.
   - Variant ALLOW_DUP=1, target 1122, guess 2211 → A=0, B=4.

Source files
------------

// File: rtl/bulls_cows_core_param_if.sv
// -----------------------------------------------------------------------------
// bulls_cows_core_param_if
// Bundle between the Bulls-and-Cows game core and its surroundings.
//   master (front end / display side):
//     drives  p0_pulse, p1_pulse, sw_val, sw_valid, lfsr_val
//     samples state, cursor, target_flat, guess_flat, candidate, cand_ok,
//             chances, result_a, result_b, result_valid
//   slave (game core): the mirror image of master.
// Widths follow the core parameters, so instantiate with the same values.
// -----------------------------------------------------------------------------
interface bulls_cows_core_param_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_CHANCES = 5
);
  localparam int CW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CHW = $clog2(MAX_CHANCES + 1);
  localparam int RW  = $clog2(NUM_DIGITS + 1);
  localparam int FW  = NUM_DIGITS * DIGIT_W;

  logic               p0_pulse;
  logic               p1_pulse;
  logic [DIGIT_W-1:0] sw_val;
  logic               sw_valid;
  logic [DIGIT_W-1:0] lfsr_val;

  logic [2:0]         state;
  logic [CW-1:0]      cursor;
  logic [FW-1:0]      target_flat;
  logic [FW-1:0]      guess_flat;
  logic [DIGIT_W-1:0] candidate;
  logic               cand_ok;
  logic [CHW-1:0]     chances;
  logic [RW-1:0]      result_a;
  logic [RW-1:0]      result_b;
  logic               result_valid;

  modport master (
    output p0_pulse, p1_pulse, sw_val, sw_valid, lfsr_val,
    input  state, cursor, target_flat, guess_flat, candidate, cand_ok,
           chances, result_a, result_b, result_valid
  );

  modport slave (
    input  p0_pulse, p1_pulse, sw_val, sw_valid, lfsr_val,
    output state, cursor, target_flat, guess_flat, candidate, cand_ok,
           chances, result_a, result_b, result_valid
  );
endinterface

// File: rtl/bulls_cows_core_param.sv
// -----------------------------------------------------------------------------
// bulls_cows_core_param
// Parametrised Bulls-and-Cows (xAyB) game controller. A single cursor walks
// from the most significant digit (NUM_DIGITS-1) down to 0 while the target
// and then each guess are entered. The commit of digit 0 of a guess scores it
// on the same clock edge.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; overrides everything
//   bcif   slave side of bulls_cows_core_param_if (buttons, switch, LFSR in;
//          state, cursor, codes, candidate, scores and chances out)
// state encoding: IDLE=0, SET=1, GUESS=2, SHOW=3, WIN=4, LOSE=5
// -----------------------------------------------------------------------------
module bulls_cows_core_param #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int RADIX       = 10,
  parameter int MAX_CHANCES = 5,
  parameter int ALLOW_DUP   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  bulls_cows_core_param_if.slave    bcif
);
  localparam int CW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CHW = $clog2(MAX_CHANCES + 1);
  localparam int RW  = $clog2(NUM_DIGITS + 1);
  localparam int FW  = NUM_DIGITS * DIGIT_W;

  localparam logic [CW-1:0]    LAST_CUR = CW'(NUM_DIGITS - 1);
  localparam logic [CHW-1:0]   FULL_CH  = CHW'(MAX_CHANCES);
  localparam logic [DIGIT_W:0] RADIX_X  = (DIGIT_W + 1)'(RADIX);
  localparam logic [RW-1:0]    ALL_HIT  = RW'(NUM_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_GUESS = 3'd2,
    S_SHOW  = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_e;

  // Bulls = positional hits; cows = multiset overlap minus bulls, which
  // handles repeated digits correctly when duplicates are allowed.
  function automatic logic [2*RW-1:0] score_f(input logic [FW-1:0] g,
                                               input logic [FW-1:0] t);
    logic [RW-1:0] bulls;
    logic [RW-1:0] common;
    logic [RW-1:0] cnt_g;
    logic [RW-1:0] cnt_t;
    bulls  = '0;
    common = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bulls = bulls + ((g[i*DIGIT_W +: DIGIT_W] == t[i*DIGIT_W +: DIGIT_W]) ? RW'(1) : RW'(0));
    end
    for (int v = 0; v < RADIX; v++) begin
      cnt_g = '0;
      cnt_t = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cnt_g = cnt_g + ((g[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v)) ? RW'(1) : RW'(0));
        cnt_t = cnt_t + ((t[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v)) ? RW'(1) : RW'(0));
      end
      common = common + ((cnt_g < cnt_t) ? cnt_g : cnt_t);
    end
    return {bulls, common - bulls};
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      cursor_q, cursor_d;
  logic [FW-1:0]      target_q, target_d;
  logic [FW-1:0]      guess_q, guess_d;
  logic [CHW-1:0]     chances_q, chances_d;
  logic [RW-1:0]      res_a_q, res_a_d;
  logic [RW-1:0]      res_b_q, res_b_d;
  logic               res_valid_q, res_valid_d;

  logic [DIGIT_W-1:0] candidate_s;
  logic               cand_ok_s;
  logic               dup_s;
  logic [FW-1:0]      entry_code_s;
  logic [FW-1:0]      scored_guess_s;
  logic [2*RW-1:0]    score_s;

  // Candidate selection: the LFSR only feeds target entry when no switch value is present.
  always_comb begin
    candidate_s = bcif.sw_val;
    if ((state_q == S_SET) && !bcif.sw_valid) begin
      candidate_s = bcif.lfsr_val;
    end else begin
      candidate_s = bcif.sw_val;
    end
  end

  // Legality of the candidate: range, switch presence in GUESS, and uniqueness
  // against digits already committed above the cursor in the code being entered.
  always_comb begin
    dup_s        = 1'b0;
    cand_ok_s    = 1'b0;
    entry_code_s = (state_q == S_SET) ? target_q : guess_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dup_s = dup_s | ((ALLOW_DUP == 0) && (CW'(i) > cursor_q) &&
                       (entry_code_s[i*DIGIT_W +: DIGIT_W] == candidate_s));
    end
    case (state_q)
      S_SET:   cand_ok_s = ({1'b0, candidate_s} < RADIX_X) && !dup_s;
      S_GUESS: cand_ok_s = ({1'b0, candidate_s} < RADIX_X) && bcif.sw_valid && !dup_s;
      default: cand_ok_s = 1'b0;
    endcase
  end

  // Score the guess as it will stand after the digit-0 commit.
  always_comb begin
    scored_guess_s = {guess_q[FW-1:DIGIT_W], candidate_s};
    score_s        = score_f(scored_guess_s, target_q);
  end

  // Next-state and datapath update; commit has priority over undo.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    target_d  = target_q;
    guess_d   = guess_q;
    chances_d = chances_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;
    case (state_q)
      S_IDLE: begin
        if (bcif.p0_pulse) begin
          state_d   = S_SET;
          cursor_d  = LAST_CUR;
          chances_d = FULL_CH;
          target_d  = '0;
          guess_d   = '0;
          res_a_d   = '0;
          res_b_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET: begin
        if (bcif.p0_pulse && cand_ok_s) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            target_d[i*DIGIT_W +: DIGIT_W] = (CW'(i) == cursor_q) ? candidate_s
                                                                  : target_q[i*DIGIT_W +: DIGIT_W];
          end
          if (cursor_q == '0) begin
            state_d  = S_GUESS;
            cursor_d = LAST_CUR;
          end else begin
            cursor_d = cursor_q - CW'(1);
          end
        end else if (bcif.p1_pulse && (cursor_q != LAST_CUR)) begin
          cursor_d = cursor_q + CW'(1);
        end else begin
          cursor_d = cursor_q;
        end
      end
      S_GUESS: begin
        if (bcif.p0_pulse && cand_ok_s) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            guess_d[i*DIGIT_W +: DIGIT_W] = (CW'(i) == cursor_q) ? candidate_s
                                                                 : guess_q[i*DIGIT_W +: DIGIT_W];
          end
          if (cursor_q == '0) begin
            res_a_d = score_s[2*RW-1:RW];
            res_b_d = score_s[RW-1:0];
            if (score_s[2*RW-1:RW] == ALL_HIT) begin
              state_d = S_WIN;
            end else if (chances_q == CHW'(1)) begin
              chances_d = '0;
              state_d   = S_LOSE;
            end else begin
              chances_d = chances_q - CHW'(1);
              state_d   = S_SHOW;
            end
          end else begin
            cursor_d = cursor_q - CW'(1);
          end
        end else if (bcif.p1_pulse && (cursor_q != LAST_CUR)) begin
          cursor_d = cursor_q + CW'(1);
        end else begin
          cursor_d = cursor_q;
        end
      end
      S_SHOW: begin
        if (bcif.p0_pulse) begin
          state_d  = S_GUESS;
          cursor_d = LAST_CUR;
        end else begin
          state_d = S_SHOW;
        end
      end
      S_WIN, S_LOSE: begin
        // Registers are deliberately left alone; IDLE->SET clears them.
        if (bcif.p0_pulse) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    res_valid_d = (state_d == S_SHOW) || (state_d == S_WIN) || (state_d == S_LOSE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cursor_q    <= LAST_CUR;
      target_q    <= '0;
      guess_q     <= '0;
      chances_q   <= FULL_CH;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      target_q    <= target_d;
      guess_q     <= guess_d;
      chances_q   <= chances_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bcif.state        = state_q;
  assign bcif.cursor       = cursor_q;
  assign bcif.target_flat  = target_q;
  assign bcif.guess_flat   = guess_q;
  assign bcif.candidate    = candidate_s;
  assign bcif.cand_ok      = cand_ok_s;
  assign bcif.chances      = chances_q;
  assign bcif.result_a     = res_a_q;
  assign bcif.result_b     = res_b_q;
  assign bcif.result_valid = res_valid_q;
endmodule
